// File: rtl/playfield_engine_if.sv
// Spawn handshake, step strobe and playfield status bundle for playfield_engine.
interface playfield_engine_if #(
  parameter int COLS       = 16,
  parameter int ROWS       = 32,
  parameter int SPAWN_ROWS = 16
);
  logic                         tick;
  logic                         spawn_valid;
  logic [COLS*SPAWN_ROWS-1:0]   spawn_data;
  logic                         spawn_ready;
  logic [COLS*ROWS-1:0]         display;
  logic                         merged;
  logic [15:0]                  lines_cleared;
  logic                         game_over;

  modport master (
    output tick, spawn_valid, spawn_data,
    input  spawn_ready, display, merged, lines_cleared, game_over
  );

  modport slave (
    input  tick, spawn_valid, spawn_data,
    output spawn_ready, display, merged, lines_cleared, game_over
  );
endinterface

// File: rtl/playfield_engine.sv
// Falling-block playfield: an active layer that steps down on tick, and in
// stack mode a settled layer that absorbs landed pieces and clears full rows.
module playfield_engine #(
  parameter int COLS       = 16,
  parameter int ROWS       = 32,
  parameter int SPAWN_ROWS = 16,
  parameter int MODE       = 1
) (
  input  logic             clock,
  input  logic             resetn,
  playfield_engine_if.slave bus
);

  localparam int K = SPAWN_ROWS + ROWS;

  typedef enum logic [1:0] {IDLE, FALL, CLEAR, OVER} state_t;

  state_t state_q, state_d;

  // Column-major layers: bit index inside a column is the row index, so
  // "down one row" is a left shift and packed flattening matches display.
  logic [COLS-1:0][K-1:0]          a_q, a_d, a_sh;
  logic [COLS-1:0][ROWS-1:0]       s_q, s_d, s_sh, vis_a, vis_a_sh;
  logic [COLS-1:0][SPAWN_ROWS-1:0] spawn_col;
  logic [ROWS-1:0]                 row_full;
  logic                            row_found;
  int unsigned                     row_sel;
  logic                            bottom_hit, overlap, in_buffer;
  logic                            handshake, spawn_ready;
  logic                            merged_q, merged_d;
  logic [15:0]                     lines_q, lines_d;

  // Shifted views, spawn columns and landing / full-row detection.
  always_comb begin
    row_full   = '1;
    bottom_hit = 1'b0;
    overlap    = 1'b0;
    in_buffer  = 1'b0;
    for (int unsigned c = 0; c < COLS; c++) begin
      a_sh[c]      = {a_q[c][K-2:0], 1'b0};
      vis_a[c]     = a_q[c][SPAWN_ROWS +: ROWS];
      vis_a_sh[c]  = a_sh[c][SPAWN_ROWS +: ROWS];
      s_sh[c]      = {s_q[c][ROWS-2:0], 1'b0};
      spawn_col[c] = bus.spawn_data[c*SPAWN_ROWS +: SPAWN_ROWS];
      bottom_hit   = bottom_hit | a_q[c][K-1];
      overlap      = overlap | (|(vis_a_sh[c] & s_q[c]));
      in_buffer    = in_buffer | (|a_q[c][SPAWN_ROWS-1:0]);
      row_full     = row_full & s_q[c];
    end
    row_found = |row_full;
    // Later (higher) rows overwrite earlier ones, leaving the bottom-most.
    row_sel = 0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (row_full[r]) row_sel = r;
    end
  end

  assign spawn_ready = (MODE == 0) ? 1'b1 : (state_q == IDLE);
  assign handshake   = bus.spawn_valid & spawn_ready;

  // Next-state logic for both layers, the mode-1 FSM and the counters.
  always_comb begin
    a_d      = a_q;
    s_d      = s_q;
    state_d  = state_q;
    merged_d = 1'b0;
    lines_d  = lines_q;
    if (MODE == 0) begin
      if (handshake) begin
        for (int unsigned c = 0; c < COLS; c++) a_d[c][SPAWN_ROWS-1:0] = spawn_col[c];
      end else if (bus.tick) begin
        a_d = a_sh;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (handshake) begin
            for (int unsigned c = 0; c < COLS; c++) a_d[c][SPAWN_ROWS-1:0] = spawn_col[c];
            state_d = FALL;
          end
        end
        FALL: begin
          if (bus.tick) begin
            if (bottom_hit || overlap) begin
              s_d      = s_q | vis_a;
              a_d      = '0;
              merged_d = 1'b1;
              state_d  = in_buffer ? OVER : CLEAR;
            end else begin
              a_d = a_sh;
            end
          end
        end
        CLEAR: begin
          if (row_found) begin
            // Only rows at or above the full row drop; rows below stay put.
            for (int unsigned c = 0; c < COLS; c++) begin
              for (int unsigned r = 0; r < ROWS; r++) begin
                if (r <= row_sel) s_d[c][r] = s_sh[c][r];
              end
            end
            if (lines_q != '1) lines_d = lines_q + 16'd1;
          end else begin
            state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= IDLE;
      a_q      <= '0;
      s_q      <= '0;
      merged_q <= 1'b0;
      lines_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      s_q      <= s_d;
      merged_q <= merged_d;
      lines_q  <= lines_d;
    end
  end

  assign bus.spawn_ready   = spawn_ready;
  assign bus.display       = s_q | vis_a;
  assign bus.merged        = merged_q;
  assign bus.lines_cleared = lines_q;
  assign bus.game_over     = (state_q == OVER);

endmodule

// File: tb/tb_playfield_engine.sv
// Directed bench for playfield_engine in scroll (MODE 0) and stack (MODE 1)
// configurations with a 4x8 playfield and 2-row spawn buffer.
module tb_playfield_engine;

  logic clock;
  logic resetn;

  playfield_engine_if #(.COLS(4), .ROWS(8), .SPAWN_ROWS(2)) if0 ();
  playfield_engine_if #(.COLS(4), .ROWS(8), .SPAWN_ROWS(2)) if1 ();

  playfield_engine #(.COLS(4), .ROWS(8), .SPAWN_ROWS(2), .MODE(0)) dut0 (
    .clock (clock),
    .resetn(resetn),
    .bus   (if0.slave)
  );

  playfield_engine #(.COLS(4), .ROWS(8), .SPAWN_ROWS(2), .MODE(1)) dut1 (
    .clock (clock),
    .resetn(resetn),
    .bus   (if1.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic tick0(input int n);
    for (int i = 0; i < n; i++) begin
      if0.tick = 1'b1;
      cyc();
      if0.tick = 1'b0;
    end
  endtask

  task automatic tick1(input int n);
    for (int i = 0; i < n; i++) begin
      if1.tick = 1'b1;
      cyc();
      if1.tick = 1'b0;
    end
  endtask

  task automatic spawn1(input logic [7:0] d);
    if1.spawn_data  = d;
    if1.spawn_valid = 1'b1;
    cyc();
    if1.spawn_valid = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cyc();
    cyc();
    resetn = 1'b1;
  endtask

  initial begin
    logic [7:0] col_mask;
    resetn          = 1'b0;
    if0.tick        = 1'b0;
    if0.spawn_valid = 1'b0;
    if0.spawn_data  = '0;
    if1.tick        = 1'b0;
    if1.spawn_valid = 1'b0;
    if1.spawn_data  = '0;
    #1;
    do_reset();

    // Reset state
    push("rst_display", 32'h0);       chk(if1.display);
    push("rst_ready", 32'h1);         chk({31'b0, if1.spawn_ready});
    push("rst_lines", 32'h0);         chk({16'b0, if1.lines_cleared});
    push("rst_game_over", 32'h0);     chk({31'b0, if1.game_over});
    push("m0_rst_ready", 32'h1);      chk({31'b0, if0.spawn_ready});

    // Scroll mode: cells (0,0),(0,1)
    if0.spawn_data  = 8'h03;
    if0.spawn_valid = 1'b1;
    push("m0_after_spawn", 32'h0);
    cyc();
    if0.spawn_valid = 1'b0;
    chk(if0.display);
    push("m0_two_ticks", 32'h0000_0003);
    tick0(2);
    chk(if0.display);
    push("m0_eight_ticks", 32'h0000_00C0);
    tick0(6);
    chk(if0.display);
    push("m0_ten_ticks", 32'h0);
    tick0(2);
    chk(if0.display);
    push("m0_merged", 32'h0);         chk({31'b0, if0.merged});
    push("m0_lines", 32'h0);          chk({16'b0, if0.lines_cleared});
    push("m0_game_over", 32'h0);      chk({31'b0, if0.game_over});

    // Stack mode: single cell (1,1) lands on tick 9
    spawn1(8'h08);
    push("m1_fall_ready", 32'h0);     chk({31'b0, if1.spawn_ready});
    tick1(8);
    push("m1_tick8_merged", 32'h0);   chk({31'b0, if1.merged});
    push("m1_tick9_merged", 32'h1);
    push("m1_tick9_display", 32'h0000_8000);
    push("m1_tick9_ready", 32'h0);
    tick1(1);
    chk({31'b0, if1.merged});
    chk(if1.display);
    chk({31'b0, if1.spawn_ready});
    push("m1_after_merged", 32'h0);
    push("m1_after_ready", 32'h1);
    cyc();
    chk({31'b0, if1.merged});
    chk({31'b0, if1.spawn_ready});

    // Stack mode: full bottom row clears
    do_reset();
    spawn1(8'hAA);
    tick1(8);
    push("clr_land_display", 32'h8080_8080);
    tick1(1);
    chk(if1.display);
    push("clr_lines", 32'h1);
    push("clr_display", 32'h0);
    push("clr_still_busy", 32'h0);
    cyc();
    chk({16'b0, if1.lines_cleared});
    chk(if1.display);
    chk({31'b0, if1.spawn_ready});
    push("clr_idle_ready", 32'h1);
    push("clr_idle_lines", 32'h1);
    cyc();
    chk({31'b0, if1.spawn_ready});
    chk({16'b0, if1.lines_cleared});

    // Spawn and tick together: piece unshifted, FSM enters FALL
    if1.spawn_data  = 8'h20;
    if1.spawn_valid = 1'b1;
    if1.tick        = 1'b1;
    push("same_cycle_display", 32'h0);
    push("same_cycle_ready", 32'h0);
    cyc();
    if1.spawn_valid = 1'b0;
    if1.tick        = 1'b0;
    chk(if1.display);
    chk({31'b0, if1.spawn_ready});
    push("same_cycle_tick1", 32'h0001_0000);
    tick1(1);
    chk(if1.display);

    // Reset in the middle of a fall (lines_cleared was 1 before)
    tick1(2);
    do_reset();
    push("midfall_display", 32'h0);   chk(if1.display);
    push("midfall_lines", 32'h0);     chk({16'b0, if1.lines_cleared});
    push("midfall_ready", 32'h1);     chk({31'b0, if1.spawn_ready});

    // Game over: four column-0 pieces fill the column, fifth cannot enter
    for (int n = 0; n < 4; n++) begin
      col_mask = 8'hFF << (6 - 2 * n);
      spawn1(8'h03);
      tick1(8 - 2 * n);
      push($sformatf("go_pre_land%0d", n), 32'h0);
      chk({31'b0, if1.merged});
      push($sformatf("go_land%0d", n), 32'h1);
      push($sformatf("go_land_display%0d", n), {24'b0, col_mask});
      tick1(1);
      chk({31'b0, if1.merged});
      chk(if1.display);
      push($sformatf("go_back_idle%0d", n), 32'h1);
      cyc();
      chk({31'b0, if1.spawn_ready});
    end
    spawn1(8'h03);
    push("go_final_merged", 32'h1);
    push("go_final_over", 32'h1);
    push("go_final_ready", 32'h0);
    tick1(1);
    chk({31'b0, if1.merged});
    chk({31'b0, if1.game_over});
    chk({31'b0, if1.spawn_ready});
    if1.spawn_valid = 1'b1;
    if1.spawn_data  = 8'hFF;
    tick1(3);
    if1.spawn_valid = 1'b0;
    push("go_held_over", 32'h1);      chk({31'b0, if1.game_over});
    push("go_held_ready", 32'h0);     chk({31'b0, if1.spawn_ready});
    push("go_held_display", 32'h0000_00FF); chk(if1.display);
    push("go_held_merged", 32'h0);    chk({31'b0, if1.merged});
    do_reset();
    push("go_reset_over", 32'h0);     chk({31'b0, if1.game_over});
    push("go_reset_display", 32'h0);  chk(if1.display);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/playfield_engine.md
PLAYFIELD_ENGINE -- requirements
Module: playfield_engine

Interface
REQ-001 Parameter COLS, default 16, number of playfield columns.
REQ-002 Parameter ROWS, default 32, number of visible rows; row 0 is the top row.
REQ-003 Parameter SPAWN_ROWS, default 16, height of the hidden spawn buffer above row 0.
REQ-004 Parameter MODE, default 1, behaviour select: 0 = scroll (cells fall off the bottom), 1 = stack (pieces land, merge, clear full rows).
REQ-005 clock  input  1  system clock; all state updates on posedge.
REQ-006 resetn  input  1  synchronous, active-low reset.
REQ-007 tick  input  1  one-cycle step strobe; each strobe moves the falling content down one row.
REQ-008 spawn_valid  input  1  a new piece is offered on spawn_data.
REQ-009 spawn_data  input  COLS*SPAWN_ROWS  piece bitmap; cell (c,r) is at bit c*SPAWN_ROWS+r.
REQ-010 spawn_ready  output  1  the engine accepts spawn_data this cycle.
REQ-011 display  output  COLS*ROWS  visible playfield; cell (c,r) is at bit c*ROWS+r.
REQ-012 merged  output  1  one-cycle pulse when the active piece lands (MODE 1 only).
REQ-013 lines_cleared  output  16  count of full rows removed since reset; saturates at 16'hFFFF.
REQ-014 game_over  output  1  a piece landed while still partly in the spawn buffer.

Function
REQ-015 Internal state: active layer A of COLS x (SPAWN_ROWS+ROWS); settled layer S of COLS x ROWS (MODE 1 only).
REQ-016 A row index k: rows 0..SPAWN_ROWS-1 are the buffer; row SPAWN_ROWS+r maps to visible row r.
REQ-017 display = S OR (visible part of A), taken directly from registers; it reflects an update on the cycle after the update edge.
REQ-018 A spawn handshake completes when spawn_valid and spawn_ready are both 1 on a clock edge.
REQ-019 On a completed handshake, A buffer rows are overwritten with spawn_data; A visible rows are unchanged.
REQ-020 If a handshake and tick occur in the same cycle, the spawn takes effect and the tick is dropped.
REQ-021 MODE 0: spawn_ready is held at 1 whenever not in reset.
REQ-022 MODE 0: on each tick, every A column shifts down one row; row 0 fills with 0 and row SPAWN_ROWS+ROWS-1 is discarded.
REQ-023 MODE 0: merged is 0, game_over is 0 and lines_cleared is 0 at all times.
REQ-024 MODE 1 FSM states: IDLE, FALL, CLEAR, OVER.
REQ-025 IDLE: spawn_ready=1; a completed handshake moves the FSM to FALL.
REQ-026 FALL: spawn_ready=0; on each tick, compute shifted A' (A moved down one row).
REQ-027 Landing condition, either of:
- A has a cell in row SPAWN_ROWS+ROWS-1 (bottom row);
- the visible part of A' overlaps S.
REQ-028 No landing: A <= A'.
REQ-029 Landing actions on the same edge:
- S <= S OR (visible part of unshifted A);
- A <= 0;
- merged pulses for one cycle.
REQ-030 After landing, the FSM moves to OVER if unshifted A had any cell in rows 0..SPAWN_ROWS-1, otherwise to CLEAR.
REQ-031 CLEAR: each cycle, find the bottom-most visible row with all COLS cells set in S.
REQ-032 CLEAR, full row found at row r:
- rows 0..r-1 of S move down one row;
- row 0 fills with 0;
- lines_cleared increments (saturating);
- the FSM stays in CLEAR.
REQ-033 CLEAR, no full row found: the FSM moves to IDLE; with no full rows, CLEAR lasts exactly one cycle.
REQ-034 OVER: game_over=1 and spawn_ready=0; tick and spawn_valid are ignored until reset.
REQ-035 In CLEAR and OVER, tick is ignored.

Reset
REQ-036 While resetn=0 at a clock edge, the engine clears its state:
- A=0, S=0;
- FSM state IDLE;
- lines_cleared=0, merged=0, game_over=0.
REQ-037 display is 0 and spawn_ready=1 on the cycle after reset deasserts.
REQ-038 Reset has priority over every other input in every state, including mid-FALL and mid-CLEAR.

Verification (COLS=4, ROWS=8, SPAWN_ROWS=2)
REQ-039 MODE 0 scroll:
- stimulus: spawn cells (0,0),(0,1), then 2 ticks;
- required: display bits 0 and 1 = 1;
- then 8 more ticks: display = 0.
REQ-040 MODE 1 single-cell landing:
- stimulus: spawn cell (1,1), then 9 ticks;
- required: merged pulses on tick 9 and display bit 1*8+7 = 1;
- spawn_ready returns to 1 two cycles after the landing edge.
REQ-041 MODE 1 row clear:
- stimulus: spawn row 1 set in all 4 columns, then 9 ticks;
- required: lines_cleared=1, display=0, FSM back in IDLE.
REQ-042 MODE 1 game over:
- stimulus: spawn column 0 rows 0-1 four times, each run to landing, giving a full visible column 0;
- then a fifth spawn and 1 tick;
- required: merged=1, then game_over=1 and spawn_ready=0, held through further ticks.
REQ-043 Reset mid-FALL: resetn=0 after 3 ticks -> display=0, lines_cleared=0, spawn_ready=1.
REQ-044 spawn_valid and tick in the same IDLE cycle -> the piece loads into the buffer rows unshifted, and the FSM enters FALL.
